// File: rtl/cp0_pkg.sv
// Shared CP0 register indices, field positions and exception codes.
// Used by the M-stage CP0 controller and its request arbiter.
package cp0_pkg;

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    localparam int IM_MSB   = 15;
    localparam int IM_LSB   = 10;
    localparam int SR_EXL   = 1;
    localparam int SR_IE    = 0;
    localparam int CAUSE_BD = 31;
    localparam int EXC_MSB  = 6;
    localparam int EXC_LSB  = 2;

    localparam logic [31:0] SR_WMASK   = 32'h0000_FC03;
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

    localparam logic [4:0] EXC_INT     = 5'd0;
    localparam logic [4:0] EXC_ADEL    = 5'd4;
    localparam logic [4:0] EXC_ADES    = 5'd5;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_RI      = 5'd10;
    localparam logic [4:0] EXC_OV      = 5'd12;

    // Restart address: a delay-slot instruction resumes at its branch.
    function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
        return bd ? pc - 32'd4 : pc;
    endfunction

endpackage

// File: rtl/cp0_req_arb.sv
// Purpose: decide whether M takes an interrupt/exception and which ExcCode it records.
// Latency: purely combinational, zero cycles.
// Backpressure: none; EXL=1 masks every new request until eret.
module cp0_req_arb
    import cp0_pkg::*;
#(
    parameter int NUM_HWINT = 6
) (
    input  logic [NUM_HWINT-1:0] im,
    input  logic                 exl,
    input  logic                 ie,
    input  logic [NUM_HWINT-1:0] hw_int,
    input  logic [4:0]           m_exc,
    output logic                 req,
    output logic                 is_int,
    output logic [4:0]           exc_code
);

    logic int_req;
    logic exc_req;

    assign int_req  = ie & ~exl & (|(hw_int & im));
    assign exc_req  = (m_exc != EXC_INT) & ~exl;
    assign req      = int_req | exc_req;
    assign is_int   = int_req;
    // Interrupts win over a synchronous exception raised in the same cycle.
    assign exc_code = int_req ? EXC_INT : m_exc;

endmodule

// File: rtl/cp0_ctrl.sv
// Purpose: CP0 SR/Cause/EPC/PRId with mfc0/mtc0/eret and the pipeline flush request.
// Latency: req and rdata are combinational; register updates land at the next clk edge.
// Backpressure: none; a taken request drops any mtc0/eret in the same cycle.
module cp0_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID      = 32'h2023_0007,
    parameter int          NUM_HWINT = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [4:0]           addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata,
    input  logic [31:0]          m_pc,
    input  logic                 m_bd,
    input  logic [4:0]           m_exc,
    input  logic                 m_eret,
    input  logic [NUM_HWINT-1:0] hw_int,
    output logic                 req,
    output logic [31:0]          epc_out
);

    logic [NUM_HWINT-1:0] im_q;
    logic [NUM_HWINT-1:0] ip_q;
    logic                 exl_q;
    logic                 ie_q;
    logic                 bd_q;
    logic [4:0]           exc_q;
    logic [31:0]          epc_q;

    logic                 arb_is_int;
    logic [4:0]           arb_exc;
    logic [31:0]          sr_val;
    logic [31:0]          cause_val;

    cp0_req_arb #(.NUM_HWINT(NUM_HWINT)) u_arb (
        .im       (im_q),
        .exl      (exl_q),
        .ie       (ie_q),
        .hw_int   (hw_int),
        .m_exc    (m_exc),
        .req      (req),
        .is_int   (arb_is_int),
        .exc_code (arb_exc)
    );

    always_comb begin
        sr_val                        = '0;
        sr_val[IM_LSB +: NUM_HWINT]   = im_q;
        sr_val[SR_EXL]                = exl_q;
        sr_val[SR_IE]                 = ie_q;

        cause_val                     = '0;
        cause_val[CAUSE_BD]           = bd_q;
        cause_val[IM_LSB +: NUM_HWINT] = ip_q;
        cause_val[EXC_MSB:EXC_LSB]    = exc_q;

        case (addr)
            REG_SR:    rdata = sr_val;
            REG_CAUSE: rdata = cause_val;
            REG_EPC:   rdata = epc_q;
            REG_PRID:  rdata = PRID;
            default:   rdata = '0;
        endcase
    end

    assign epc_out = epc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            im_q  <= '0;
            ip_q  <= '0;
            exl_q <= 1'b0;
            ie_q  <= 1'b0;
            bd_q  <= 1'b0;
            exc_q <= '0;
            epc_q <= '0;
        end else begin
            ip_q <= hw_int;
            if (req) begin
                exl_q <= 1'b1;
                bd_q  <= m_bd;
                exc_q <= arb_is_int ? EXC_INT : arb_exc;
                epc_q <= epc_of(m_pc, m_bd);
            end else begin
                if (m_eret) begin
                    exl_q <= 1'b0;
                end
                // Cause and PRId are read-only to software.
                if (we) begin
                    case (addr)
                        REG_SR: begin
                            im_q  <= wdata[IM_LSB +: NUM_HWINT];
                            exl_q <= wdata[SR_EXL];
                            ie_q  <= wdata[SR_IE];
                        end
                        REG_EPC: epc_q <= wdata;
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_cp0_ctrl.sv
// Bench for cp0_ctrl: directed vector table, then randomized traffic against a word-level model.
module tb_cp0_ctrl;

    localparam logic [31:0] PRID_V = 32'h2023_0007;

    logic        clk = 1'b0;
    logic        reset, we, m_bd, m_eret, req;
    logic [4:0]  addr, m_exc;
    logic [31:0] wdata, rdata, m_pc, epc_out;
    logic [5:0]  hw_int;

    always #5 clk = ~clk;

    cp0_ctrl #(.PRID(PRID_V), .NUM_HWINT(6)) dut (
        .clk(clk), .reset(reset), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata),
        .m_pc(m_pc), .m_bd(m_bd), .m_exc(m_exc), .m_eret(m_eret), .hw_int(hw_int),
        .req(req), .epc_out(epc_out)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] pc;
        logic        bd;
        logic [4:0]  exc;
        logic        eret;
        logic [5:0]  hw;
        logic        e_req;
        logic [31:0] e_rdata;
        logic [31:0] e_epc;
    } vec_t;

    vec_t tbl[$];

    task automatic v(input logic rst, input logic w, input logic [4:0] a, input logic [31:0] wd,
                     input logic [31:0] pc, input logic bd, input logic [4:0] exc, input logic er,
                     input logic [5:0] hw, input logic e_req, input logic [31:0] e_rd,
                     input logic [31:0] e_epc);
        vec_t t;
        t.rst = rst; t.we = w; t.addr = a; t.wdata = wd; t.pc = pc; t.bd = bd; t.exc = exc;
        t.eret = er; t.hw = hw; t.e_req = e_req; t.e_rdata = e_rd; t.e_epc = e_epc;
        tbl.push_back(t);
    endtask

    task automatic drive(input logic rst, input logic w, input logic [4:0] a, input logic [31:0] wd,
                         input logic [31:0] pc, input logic bd, input logic [4:0] exc,
                         input logic er, input logic [5:0] hw);
        reset = rst; we = w; addr = a; wdata = wd; m_pc = pc; m_bd = bd; m_exc = exc;
        m_eret = er; hw_int = hw;
    endtask

    // Reference model: architectural registers held as whole 32-bit words.
    logic [31:0] md_sr, md_cause, md_epc;

    function automatic logic model_int();
        return md_sr[0] && !md_sr[1] && ((hw_int & md_sr[15:10]) != 6'd0);
    endfunction

    function automatic logic model_req();
        return model_int() || ((m_exc != 5'd0) && !md_sr[1]);
    endfunction

    function automatic logic [31:0] model_rdata();
        if (addr == 5'd12) return md_sr;
        if (addr == 5'd13) return md_cause;
        if (addr == 5'd14) return md_epc;
        if (addr == 5'd15) return PRID_V;
        return 32'd0;
    endfunction

    task automatic model_clock();
        logic        taken, intr;
        logic [31:0] code;
        taken = model_req();
        intr  = model_int();
        if (reset) begin
            md_sr = 0; md_cause = 0; md_epc = 0;
        end else begin
            md_cause = (md_cause & ~32'h0000_FC00) | ({26'd0, hw_int} << 10);
            if (taken) begin
                code     = intr ? 32'd0 : {27'd0, m_exc};
                md_sr    = md_sr | 32'h2;
                md_cause = (md_cause & 32'h0000_FC00) | ({31'd0, m_bd} << 31) | (code << 2);
                md_epc   = m_bd ? m_pc - 32'd4 : m_pc;
            end else begin
                if (m_eret) md_sr = md_sr & ~32'h2;
                if (we && addr == 5'd12) md_sr = wdata & 32'h0000_FC03;
                if (we && addr == 5'd14) md_epc = wdata;
            end
        end
    endtask

    initial begin
        int codes[6];
        logic [4:0] a;
        codes = '{0, 4, 5, 8, 10, 12};

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);

        //  rst we addr  wdata          pc             bd exc  eret hw        req rdata          epc
        v(0, 0, 12, 0,             0,             0, 0,  0, 6'b000000, 0, 32'h0,         32'h0);
        v(0, 0, 13, 0,             0,             0, 0,  0, 6'b000000, 0, 32'h0,         32'h0);
        v(0, 0, 14, 0,             0,             0, 0,  0, 6'b000000, 0, 32'h0,         32'h0);
        v(0, 1, 12, 32'hFFFF_FFFF, 0,             0, 0,  0, 6'b000000, 0, 32'h0,         32'h0);
        v(0, 0, 12, 0,             0,             0, 0,  0, 6'b000000, 0, 32'h0000_FC03, 32'h0);
        v(0, 1, 13, 32'hFFFF_FFFF, 0,             0, 0,  0, 6'b000000, 0, 32'h0,         32'h0);
        v(0, 0, 13, 0,             0,             0, 0,  0, 6'b000000, 0, 32'h0,         32'h0);
        v(0, 0, 15, 0,             0,             0, 0,  0, 6'b000000, 0, PRID_V,        32'h0);
        v(0, 0, 3,  0,             0,             0, 0,  0, 6'b000000, 0, 32'h0,         32'h0);
        v(0, 1, 12, 32'h0000_0401, 0,             0, 0,  0, 6'b000000, 0, 32'h0000_FC03, 32'h0);
        v(0, 0, 12, 0,             32'h3010,      0, 0,  0, 6'b000001, 1, 32'h0000_0401, 32'h0);
        v(0, 0, 13, 0,             32'h3014,      0, 0,  0, 6'b000001, 0, 32'h0000_0400, 32'h3010);
        v(0, 0, 12, 0,             32'h3018,      0, 0,  0, 6'b000001, 0, 32'h0000_0403, 32'h3010);
        v(0, 0, 14, 0,             0,             0, 0,  1, 6'b000001, 0, 32'h3010,      32'h3010);
        v(0, 0, 12, 0,             32'h3100,      0, 0,  0, 6'b000001, 1, 32'h0000_0401, 32'h3010);
        v(0, 0, 14, 0,             0,             0, 0,  0, 6'b000000, 0, 32'h3100,      32'h3100);
        v(0, 1, 12, 0,             0,             0, 0,  0, 6'b000000, 0, 32'h0000_0403, 32'h3100);
        v(0, 0, 12, 0,             32'h3024,      1, 12, 0, 6'b000000, 1, 32'h0,         32'h3100);
        v(0, 0, 13, 0,             0,             0, 0,  0, 6'b000000, 0, 32'h8000_0030, 32'h3020);
        v(0, 0, 12, 0,             32'h3030,      0, 8,  0, 6'b000000, 0, 32'h0000_0002, 32'h3020);
        v(0, 0, 13, 0,             0,             0, 0,  1, 6'b000000, 0, 32'h8000_0030, 32'h3020);
        v(0, 1, 12, 32'h0000_1001, 0,             0, 0,  0, 6'b000000, 0, 32'h0,         32'h3020);
        v(0, 1, 14, 32'h0000_5000, 32'h3200,      0, 10, 0, 6'b000100, 1, 32'h3020,      32'h3020);
        v(0, 0, 13, 0,             0,             0, 0,  0, 6'b000000, 0, 32'h0000_1000, 32'h3200);
        v(0, 0, 12, 0,             0,             0, 0,  1, 6'b000100, 0, 32'h0000_1003, 32'h3200);
        v(0, 0, 13, 0,             32'h3300,      0, 0,  0, 6'b000100, 1, 32'h0000_1000, 32'h3200);
        v(0, 0, 14, 0,             0,             0, 0,  0, 6'b000000, 0, 32'h3300,      32'h3300);
        v(0, 1, 14, 32'h3400,      0,             0, 0,  0, 6'b000000, 0, 32'h3300,      32'h3300);
        v(1, 0, 14, 0,             0,             0, 0,  0, 6'b000000, 0, 32'h3400,      32'h3400);
        v(0, 0, 12, 0,             0,             0, 0,  0, 6'b000000, 0, 32'h0,         32'h0);
        v(0, 0, 13, 0,             0,             0, 0,  0, 6'b000000, 0, 32'h0,         32'h0);
        v(0, 0, 14, 0,             32'h0,         1, 4,  0, 6'b000000, 1, 32'h0,         32'h0);
        v(0, 0, 13, 0,             0,             0, 0,  0, 6'b000000, 0, 32'h8000_0010, 32'hFFFF_FFFC);

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].pc, tbl[i].bd,
                  tbl[i].exc, tbl[i].eret, tbl[i].hw);
            #1;
            chk($sformatf("row%0d_req", i), {31'd0, req}, {31'd0, tbl[i].e_req});
            chk($sformatf("row%0d_rdata", i), rdata, tbl[i].e_rdata);
            chk($sformatf("row%0d_epc", i), epc_out, tbl[i].e_epc);
        end

        // Hand sequence: mtc0 EPC and eret in the same cycle both take effect.
        @(negedge clk); drive(0, 1, 14, 32'h0000_7000, 0, 0, 0, 1, 0);
        @(negedge clk); drive(0, 0, 12, 0, 0, 0, 0, 0, 0); #1;
        chk("we_eret_sr", rdata, 32'h0);
        chk("we_eret_epc", epc_out, 32'h0000_7000);

        // Randomized traffic against the model, starting from a known reset.
        @(negedge clk); drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        md_sr = 0; md_cause = 0; md_epc = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            case ($urandom_range(0, 4))
                0: a = 5'd12;
                1: a = 5'd13;
                2: a = 5'd14;
                3: a = 5'd15;
                default: a = 5'($urandom_range(0, 31));
            endcase
            reset  = ($urandom_range(0, 99) == 0);
            we     = ($urandom_range(0, 3) == 0);
            addr   = a;
            wdata  = $urandom;
            m_pc   = $urandom;
            m_bd   = $urandom_range(0, 1) == 1;
            m_exc  = ($urandom_range(0, 3) == 0) ? 5'(codes[$urandom_range(1, 5)]) : 5'd0;
            m_eret = ($urandom_range(0, 5) == 0) && !(we && a == 5'd12);
            hw_int = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
            #1;
            chk($sformatf("rnd%0d_req", i), {31'd0, req}, {31'd0, model_req()});
            chk($sformatf("rnd%0d_rdata", i), rdata, model_rdata());
            chk($sformatf("rnd%0d_epc", i), epc_out, md_epc);
            model_clock();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
